serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 21 ++
 rtl/fs_cell.sv | 13 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// helpers that derive the slice count and counter width from WIDTH/STEP.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of RUN cycles for one operation.
  function automatic int calc_n(input int width, input int step);
    return width / step;
  endfunction

  // Slice counter width; a single-slice operation still needs one bit.
  function automatic int calc_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = x - y - c, bo is the borrow out.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ c;
  assign bo = (~x & y) | (~x & c) | (y & c);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: a - b - bin, STEP bits per clock, LSB slice first.
// Results are only published on the final slice so outputs never show partials.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N     = calc_n(WIDTH, STEP);
  localparam int CNT_W = calc_cnt_w(N);

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, acc_nxt;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q, ovf_q, borrow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [STEP-1:0]    d;
  logic [STEP:0]      c;
  logic               accept, last_slice;

  assign accept     = start && (state_q != RUN);
  assign last_slice = (cnt_q == CNT_W'(N - 1));

  // Slice datapath: STEP cells rippling the borrow from the registered one.
  assign c[0] = borrow_q;
  for (genvar i = 0; i < STEP; i++) begin : g_cell
    fs_cell u_cell (
      .x  (a_q[i]),
      .y  (b_q[i]),
      .c  (c[i]),
      .d  (d[i]),
      .bo (c[i+1])
    );
  end

  // New slice lands at the top; after N shifts the LSB slice sits at bit 0.
  assign acc_nxt = (acc_q >> STEP) | (WIDTH'(d) << (WIDTH - STEP));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_slice) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      acc_q    <= '0;
      borrow_q <= bin;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      a_q      <= a_q >> STEP;
      b_q      <= b_q >> STEP;
      acc_q    <= acc_nxt;
      borrow_q <= c[STEP];
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last_slice) begin
        diff_q <= acc_nxt;
        bout_q <= c[STEP];
        // c[STEP-1] is the borrow into the MSB cell.
        ovf_q  <= c[STEP] ^ c[STEP-1];
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor across WIDTH/STEP = 8/1, 8/4 and 1/1.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 0, bin8 = 0, bout8, ovf8, busy8, done8;
  logic [7:0] a8 = 0, b8 = 0, diff8;
  logic       start4 = 0, bin4 = 0, bout4, ovf4, busy4, done4;
  logic [7:0] a4 = 0, b4 = 0, diff4;
  logic       start1 = 0, bin1 = 0, bout1, ovf1, busy1, done1;
  logic [0:0] a1 = 0, b1 = 0, diff1;

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(8), .STEP(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .bout(bout8), .ovf(ovf8), .busy(busy8), .done(done8));

  serial_subtractor #(.WIDTH(8), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .diff(diff4), .bout(bout4), .ovf(ovf4), .busy(busy4), .done(done4));

  serial_subtractor #(.WIDTH(1), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .diff(diff1), .bout(bout1), .ovf(ovf1), .busy(busy1), .done(done1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({diff8, bout8, ovf8, busy8, done8} !== 12'h000) begin
      failures++;
      $display("FAIL reset_w8s1 got=%h expected=000", {diff8, bout8, ovf8, busy8, done8});
    end
    checks++;
    if ({diff4, bout4, ovf4, busy4, done4} !== 12'h000) begin
      failures++;
      $display("FAIL reset_w8s4 got=%h expected=000", {diff4, bout4, ovf4, busy4, done4});
    end
    checks++;
    if ({diff1, bout1, ovf1, busy1, done1} !== 5'h00) begin
      failures++;
      $display("FAIL reset_w1s1 got=%h expected=00", {diff1, bout1, ovf1, busy1, done1});
    end
    rst = 1'b0;
    tick();
  endtask

  // 0x00 - 0x01 wraps to 0xFF with a borrow; busy for exactly 8 cycles.
  task automatic test_basic();
    int lat, busy_cnt;
    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    busy_cnt = busy8 ? 1 : 0;
    lat = 0;
    while (!done8 && lat < 20) begin
      tick();
      lat++;
      if (!done8 && busy8) busy_cnt++;
    end
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL basic_latency got=%0d expected=8", lat);
    end
    checks++;
    if (busy_cnt != 8) begin
      failures++;
      $display("FAIL basic_busy_cycles got=%0d expected=8", busy_cnt);
    end
    checks++;
    if ({diff8, bout8, ovf8, busy8} !== {8'hFF, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_result got diff=%h bout=%b ovf=%b busy=%b expected FF/1/0/0",
               diff8, bout8, ovf8, busy8);
    end
    tick();
    checks++;
    if (done8 !== 1'b0 || diff8 !== 8'hFF) begin
      failures++;
      $display("FAIL basic_done_pulse got done=%b diff=%h expected 0/FF", done8, diff8);
    end
  endtask

  // 0x80 - 1 overflows; a start in the DONE cycle launches 0x05 - 0x03.
  task automatic test_back_to_back();
    int lat;
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 8 || {diff8, bout8, ovf8} !== {8'h7F, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d diff=%h bout=%b ovf=%b expected 8/7F/0/1",
               lat, diff8, bout8, ovf8);
    end
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_dead_cycle got busy=%b done=%b expected 1/0", busy8, done8);
    end
    tick(); tick();
    checks++;
    if (diff8 !== 8'h7F || ovf8 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_hold_midrun got diff=%h ovf=%b expected 7F/1", diff8, ovf8);
    end
    lat = 2;
    while (!done8 && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 8 || {diff8, bout8, ovf8} !== {8'h02, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d diff=%h bout=%b ovf=%b expected 8/02/0/0",
               lat, diff8, bout8, ovf8);
    end
    tick();
  endtask

  // Four bits per clock: 0x35 - 0x35 - 1 = 0xFF in two cycles.
  task automatic test_step4();
    int lat;
    a4 = 8'h35; b4 = 8'h35; bin4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL step4_latency got=%0d expected=2", lat);
    end
    checks++;
    if ({diff4, bout4, ovf4} !== {8'hFF, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL step4_result got diff=%h bout=%b ovf=%b expected FF/1/0", diff4, bout4, ovf4);
    end
    tick();
  endtask

  // Start held high during RUN with changing operands must not disturb 0x10 - 0x03.
  task automatic test_start_ignored();
    int lat, pulses;
    a8 = 8'h10; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    tick();
    lat = 0;
    while (!done8 && lat < 20) begin
      a8 = 8'hFF - 8'(lat); b8 = 8'(lat); bin8 = lat[0];
      tick();
      lat++;
    end
    start8 = 1'b0;
    pulses = done8 ? 1 : 0;
    checks++;
    if (lat != 8 || {diff8, bout8, ovf8} !== {8'h0D, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL ignore_start_result got lat=%0d diff=%h bout=%b ovf=%b expected 8/0D/0/0",
               lat, diff8, bout8, ovf8);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done8) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL ignore_start_pulses got=%0d expected=1", pulses);
    end
  endtask

  // Reset in the third RUN cycle aborts; a fresh start then runs cleanly.
  task automatic test_reset_abort();
    int lat, pulses;
    a8 = 8'h22; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    rst = 1'b1; start8 = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    checks++;
    if ({diff8, bout8, ovf8, busy8, done8} !== 12'h000) begin
      failures++;
      $display("FAIL abort_clear got=%h expected=000", {diff8, bout8, ovf8, busy8, done8});
    end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done8 || busy8) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d expected=0", pulses);
    end
    a8 = 8'h22; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 8 || {diff8, bout8, ovf8} !== {8'h11, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL abort_restart got lat=%0d diff=%h bout=%b ovf=%b expected 8/11/0/0",
               lat, diff8, bout8, ovf8);
    end
    tick();
  endtask

  // Full-subtractor truth table, index = {a, b, bin}.
  task automatic test_width1();
    logic [7:0] d_tab, bo_tab, ov_tab;
    logic [2:0] idx;
    d_tab = 8'h96; bo_tab = 8'h8E; ov_tab = 8'h24;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      a1 = idx[2]; b1 = idx[1]; bin1 = idx[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      checks++;
      if ({done1, diff1, bout1, ovf1} !== {1'b1, d_tab[i], bo_tab[i], ov_tab[i]}) begin
        failures++;
        $display("FAIL width1_idx%0d got done=%b d=%b bo=%b ovf=%b expected 1/%b/%b/%b",
                 i, done1, diff1, bout1, ovf1, d_tab[i], bo_tab[i], ov_tab[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_step4();
    test_start_ignored();
    test_reset_abort();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
